// File: rtl/led_strip_driver.sv
// ---------------------------------------------------------------------------
// led_strip_driver
//   WS2812-style single-wire serialiser. It walks led_number across the
//   strip, samples the combinational GRB bytes returned by the screen
//   pipeline and sends each 24-bit pixel MSB first (G[7] first). Every frame
//   ends with a low latch gap, followed by a one-cycle frame_done pulse.
//
//   Optional feature macro: LED_STRIP_CONTINUOUS_EN
//     When defined, the driver restarts at LED 0 straight after each latch
//     gap, keeping busy high and ignoring start (continuous refresh).
//     When undefined, the driver returns to IDLE and waits for start.
//
// Ports
//   clk                : system clock, rising edge
//   rst_n              : asynchronous active-low reset
//   start              : frame request, sampled only in IDLE
//   led_number         : index of the pixel requested upstream (registered)
//   i_green_intensity  : G byte for led_number (combinational return)
//   i_red_intensity    : R byte for led_number
//   i_blue_intensity   : B byte for led_number
//   data_out           : serial strip line (registered)
//   busy               : frame in progress
//   frame_done         : one-cycle pulse once the latch gap has elapsed
// ---------------------------------------------------------------------------
module led_strip_driver #(
    parameter int MAX_POS      = 109,
    parameter int T_BIT        = 62,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int RESET_CYCLES = 3000,
    localparam int LED_W       = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [LED_W-1:0] led_number,
    input  logic [7:0]       i_green_intensity,
    input  logic [7:0]       i_red_intensity,
    input  logic [7:0]       i_blue_intensity,
    output logic             data_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int CYC_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int LAT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(MAX_POS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [LED_W-1:0]  led_n;
    logic [23:0]       shreg, shreg_n;
    logic [4:0]        bit_cnt, bit_n;
    logic [CYC_W-1:0]  cyc_cnt, cyc_n;
    logic [LAT_W-1:0]  lat_cnt, lat_n;
    logic              busy_n, done_n, data_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            led_number <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            lat_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= 1'b0;
        end else begin
            state      <= state_n;
            led_number <= led_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_n;
            cyc_cnt    <= cyc_n;
            lat_cnt    <= lat_n;
            busy       <= busy_n;
            frame_done <= done_n;
            data_out   <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        led_n   = led_number;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        cyc_n   = cyc_cnt;
        lat_n   = lat_cnt;
        busy_n  = busy;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                led_n = '0;
                if (start) begin
                    state_n = LOAD;
                    busy_n  = 1'b1;
                end
            end
            LOAD: begin
                shreg_n = {i_green_intensity, i_red_intensity, i_blue_intensity};
                bit_n   = 5'd23;
                cyc_n   = '0;
                state_n = SEND;
            end
            SEND: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_n   = '0;
                    shreg_n = {shreg[22:0], 1'b0};
                    if (bit_cnt == 5'd0) begin
                        if (led_number == LED_LAST) begin
                            lat_n   = '0;
                            state_n = LATCH;
                        end else begin
                            led_n   = led_number + LED_W'(1);
                            state_n = LOAD;
                        end
                    end else begin
                        bit_n = bit_cnt - 5'd1;
                    end
                end else begin
                    cyc_n = cyc_cnt + CYC_W'(1);
                end
            end
            LATCH: begin
                if (lat_cnt == LAT_LAST) begin
                    done_n  = 1'b1;
                    led_n   = '0;
`ifdef LED_STRIP_CONTINUOUS_EN
                    state_n = LOAD;
`else
                    state_n = IDLE;
                    busy_n  = 1'b0;
`endif
                end else begin
                    lat_n = lat_cnt + LAT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // data_out is registered, so it is computed from the values the
        // counters take after this edge; the line then reflects the current
        // bit position with no extra cycle of lag.
        data_n = (state_n == SEND) &&
                 (cyc_n < (shreg_n[23] ? T1H_C : T0H_C));
    end

endmodule

// File: tb/tb_led_strip_driver.sv
// ---------------------------------------------------------------------------
// tb_led_strip_driver
//   Scoreboard bench. Stimulus loads per-index pixel tables, issues start and
//   pushes the expected pixels and frame_done cycle into queues. A monitor
//   decodes data_out pulse widths back into 24-bit pixels and pops/compares.
// ---------------------------------------------------------------------------
module tb_led_strip_driver;

    localparam int MAX_POS = 3;
    localparam int T_BIT   = 10;
    localparam int T0H     = 3;
    localparam int T1H     = 7;
    localparam int RC      = 20;
    localparam int LED_CYC = 1 + 24 * T_BIT;
    localparam int FRAME   = MAX_POS * LED_CYC + RC;   // 743

    typedef struct {
        int          idx;
        logic [23:0] pix;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] led_number;
    logic [7:0] g_in, r_in, b_in;
    logic       data_out, busy, frame_done;

    logic [7:0] g_arr [MAX_POS];
    logic [7:0] r_arr [MAX_POS];
    logic [7:0] b_arr [MAX_POS];

    pix_t pix_q   [$];
    int   frame_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    led_strip_driver #(
        .MAX_POS(MAX_POS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .led_number(led_number),
        .i_green_intensity(g_in), .i_red_intensity(r_in), .i_blue_intensity(b_in),
        .data_out(data_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Upstream screen pipeline: combinational lookup by index.
    always_comb begin
        g_in = 8'h00; r_in = 8'h00; b_in = 8'h00;
        if (int'(led_number) < MAX_POS) begin
            g_in = g_arr[led_number];
            r_in = r_arr[led_number];
            b_in = b_arr[led_number];
        end
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cycle);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_do = 1'b0;
    int          last_rise = 0;
    int          nbits = 0;
    logic [23:0] acc = '0;
    int          first_led = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_do = 1'b0;
            nbits   = 0;
            acc     = '0;
            pix_q.delete();
            frame_q.delete();
        end else begin
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    chk(1'b0, "unexpected_frame_done", cycle, -1);
                end else begin
                    int e;
                    e = frame_q.pop_front();
                    chk(cycle == e, "frame_done_cycle", cycle, e);
`ifdef LED_STRIP_CONTINUOUS_EN
                    chk(busy == 1'b1, "busy_at_done", int'(busy), 1);
`else
                    chk(busy == 1'b0, "busy_at_done", int'(busy), 0);
`endif
                end
            end
            if (data_out && !prev_do) begin
                if (nbits > 0)
                    chk(cycle - last_rise == T_BIT, "bit_period", cycle - last_rise, T_BIT);
                else
                    first_led = int'(led_number);
                last_rise = cycle;
            end
            if (!data_out && prev_do) begin
                int w;
                w = cycle - last_rise;
                chk(w == T0H || w == T1H, "pulse_width", w, (w > (T0H + T1H) / 2) ? T1H : T0H);
                acc = {acc[22:0], (w == T1H)};
                nbits++;
                if (nbits == 24) begin
                    nbits = 0;
                    if (pix_q.size() == 0) begin
                        chk(1'b0, "unexpected_pixel", int'(acc), -1);
                    end else begin
                        pix_t p;
                        p = pix_q.pop_front();
                        chk(acc == p.pix, "pixel_value", int'(acc), int'(p.pix));
                        chk(first_led == p.idx, "pixel_index", first_led, p.idx);
                        chk(int'(led_number) == p.idx, "led_number_stable", int'(led_number), p.idx);
                    end
                end
            end
            prev_do = data_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_tables(input int kind);
        for (int i = 0; i < MAX_POS; i++) begin
            case (kind)
                0: begin g_arr[i] = 8'h80; r_arr[i] = 8'h00;        b_arr[i] = 8'h01; end
                1: begin g_arr[i] = 8'h00; r_arr[i] = 8'(i + 1);    b_arr[i] = 8'h00; end
                default: begin
                    g_arr[i] = 8'($urandom);
                    r_arr[i] = 8'($urandom);
                    b_arr[i] = 8'($urandom);
                end
            endcase
        end
    endtask

    // Issue start at the next edge; returns that edge's cycle number.
    task automatic issue_start(input int npix, input int nframes, output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cycle + 1;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < npix; i++) begin
                pix_t p;
                p.idx = i;
                p.pix = {g_arr[i], r_arr[i], b_arr[i]};
                pix_q.push_back(p);
            end
            if (npix == MAX_POS) frame_q.push_back(t0 + (f + 1) * FRAME);
        end
        @(negedge clk);
        start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", int'(busy), 1);
        chk(led_number == 2'd0, "led0_after_start", int'(led_number), 0);
    endtask

    task automatic wait_drain(input int budget, input bit mid_start);
        int n;
        n = 0;
        while ((frame_q.size() != 0 || pix_q.size() != 0) && n < budget) begin
            @(negedge clk);
            if (mid_start) start = (n == 300);
            n++;
        end
        start = 1'b0;
        chk(frame_q.size() == 0 && pix_q.size() == 0, "frame_timeout",
            frame_q.size() + pix_q.size(), 0);
    endtask

    initial begin
        int t0;
        for (int i = 0; i < MAX_POS; i++) begin
            g_arr[i] = '0; r_arr[i] = '0; b_arr[i] = '0;
        end
        #1;
        chk(data_out == 1'b0 && busy == 1'b0 && frame_done == 1'b0 && led_number == 2'd0,
            "reset_values", {int'(data_out), int'(busy), int'(frame_done)}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset with start low.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk(data_out == 1'b0 && busy == 1'b0 && frame_done == 1'b0 && led_number == 2'd0,
                "idle_outputs", {int'(data_out), int'(busy), int'(frame_done), int'(led_number)}, 0);
        end

`ifdef LED_STRIP_CONTINUOUS_EN
        load_tables(2);
        issue_start(MAX_POS, 3, t0);
        wait_drain(4 * FRAME, 1'b0);
        chk(busy == 1'b1, "busy_continuous", int'(busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`else
        // Constant pixel, then index-dependent pixel.
        load_tables(0);
        issue_start(MAX_POS, 1, t0);
        wait_drain(2 * FRAME, 1'b0);
        load_tables(1);
        issue_start(MAX_POS, 1, t0);
        wait_drain(2 * FRAME, 1'b0);

        // Random frame with a start pulse mid-frame; nothing must follow.
        load_tables(2);
        issue_start(MAX_POS, 1, t0);
        wait_drain(2 * FRAME, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk(busy == 1'b0 && data_out == 1'b0, "no_second_frame",
                {int'(busy), int'(data_out)}, 0);
        end

        // Reset during LED 1, bit 5 (data_out is high at this point).
        load_tables(2);
        issue_start(1, 1, t0);
        while (cycle < t0 + LED_CYC + 1 + 5 * T_BIT) @(negedge clk);
        chk(pix_q.size() == 0, "led0_before_reset", pix_q.size(), 0);
        chk(data_out == 1'b1, "high_before_reset", int'(data_out), 1);
        rst_n = 1'b0;
        #1;
        chk(data_out == 1'b0, "reset_drops_line", int'(data_out), 0);
        chk(busy == 1'b0 && led_number == 2'd0, "reset_clears_state",
            {int'(busy), int'(led_number)}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fresh frames after reset must start at LED 0.
        for (int k = 0; k < 2; k++) begin
            load_tables(2);
            issue_start(MAX_POS, 1, t0);
            wait_drain(2 * FRAME, 1'b0);
        end
`endif
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
